// File: rtl/stepdown_gate_sequencer.sv
// Break-before-make HS/LS gate sequencer for the stepdown power stage.
// The outputs are decoded from the registered state. OCP cuts the HS pulse short, ZCD ends the LS pulse early, and repeated OCP latches a fault.
module stepdown_gate_sequencer #(
  parameter int TW        = 6,
  parameter int DT_HS     = 3,
  parameter int DT_LS     = 2,
  parameter int MIN_ON    = 4,
  parameter int MIN_OFF   = 3,
  parameter int OCP_LIMIT = 4
) (
  input  logic       CELCLK,
  input  logic       CELRST,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       en,
  input  logic       pwm_req,
  input  logic       ocp,
  input  logic       zcd,
  output logic       hs_on,
  output logic       ls_on,
  output logic       fault,
  output logic [3:0] ocp_cnt
);

  typedef enum logic [2:0] {
    S_OFF, S_DT_H, S_HS_ON, S_DT_L, S_LS_ON, S_DCM
  } state_t;

  localparam logic [TW-1:0] DT_HS_END   = TW'(DT_HS - 1);
  localparam logic [TW-1:0] DT_LS_END   = TW'(DT_LS - 1);
  localparam logic [TW-1:0] MIN_ON_END  = TW'(MIN_ON - 1);
  localparam logic [TW-1:0] MIN_OFF_END = TW'(MIN_OFF - 1);
  localparam logic [3:0]    OCP_LIM     = 4'(OCP_LIMIT);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          shut_q, shut_d;
  logic          fault_q, fault_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cnt_inc;

  logic unused_ties;
  assign unused_ties = CELV ^ CELG ^ SUB;

  assign cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    shut_d  = shut_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    // Disabling the converter releases a latched fault and its OCP history.
    if (!en) begin
      fault_d = 1'b0;
      cnt_d   = 4'd0;
    end
    case (state_q)
      S_OFF: begin
        if (en && !fault_q && pwm_req) state_d = S_DT_H;
      end
      S_DT_H: begin
        if (!en)                         state_d = S_OFF;
        else if (timer_q == DT_HS_END)   state_d = S_HS_ON;
      end
      S_HS_ON: begin
        if (ocp) begin
          state_d = S_DT_L;
          cnt_d   = cnt_inc;
          fault_d = fault_q | (cnt_inc >= OCP_LIM);
        end else if (!en) begin
          state_d = S_DT_L;
          shut_d  = 1'b1;
        end else if (timer_q >= MIN_ON_END && !pwm_req) begin
          state_d = S_DT_L;
          cnt_d   = 4'd0;
        end
      end
      S_DT_L: begin
        if (timer_q == DT_LS_END) begin
          shut_d  = 1'b0;
          state_d = (shut_q || fault_q) ? S_OFF : S_LS_ON;
        end
      end
      S_LS_ON: begin
        if (!en)                                    state_d = S_OFF;
        else if (zcd)                               state_d = S_DCM;
        else if (timer_q >= MIN_OFF_END && pwm_req) state_d = S_DT_H;
      end
      S_DCM: begin
        if (!en)          state_d = S_OFF;
        else if (pwm_req) state_d = S_DT_H;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)  timer_d = '0;
    else if (timer_q != '1)  timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      state_q <= S_OFF;
      timer_q <= '0;
      shut_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      shut_q  <= shut_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hs_on   = (state_q == S_HS_ON);
  assign ls_on   = (state_q == S_LS_ON);
  assign fault   = fault_q;
  assign ocp_cnt = cnt_q;

endmodule
